// File: rtl/if_stage_if.sv
// if_stage_if: signal bundle between the fetch stage and its environment
// (hazard/branch control in, instruction memory, IF/ID register and perf
// counters out). master = fetch stage, slave = surrounding pipeline/memory.
interface if_stage_if;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instru;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instru;
   logic [31:0] cnt_fetched;
   logic [31:0] cnt_stall;
   logic [31:0] cnt_flush;

   modport master (
      input  stall, flush, redirect, redirect_pc, imem_instru,
      output imem_addr, id_valid, id_pc, id_pc_plus4, id_instru,
             cnt_fetched, cnt_stall, cnt_flush
   );

   modport slave (
      output stall, flush, redirect, redirect_pc, imem_instru,
      input  imem_addr, id_valid, id_pc, id_pc_plus4, id_instru,
             cnt_fetched, cnt_stall, cnt_flush
   );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, addresses a combinational
// instruction memory and captures the returned word into the IF/ID register.
// Optional perf counters are built when IF_PERF_CNT_EN is defined; otherwise
// the cnt_* outputs are tied to zero and no counter flops exist.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input logic        clk,
   input logic        reset,
   if_stage_if.master bus
);

   logic [31:0] pc_q, pc_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
   logic [31:0] id_instru_q, id_instru_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   // next PC and IF/ID contents: redirect > flush/stall > normal fetch
   always_comb begin
      pc_d          = pc_q;
      id_valid_d    = id_valid_q;
      id_pc_d       = id_pc_q;
      id_pc_plus4_d = id_pc_plus4_q;
      id_instru_d   = id_instru_q;
      if (bus.redirect) begin
         pc_d          = {bus.redirect_pc[31:2], 2'b00};
         id_valid_d    = 1'b0;
         id_pc_d       = 32'h0;
         id_pc_plus4_d = 32'h0;
         id_instru_d   = NOP_INSTR;
      end else if (bus.flush) begin
         // flush squashes IF/ID, but a concurrent stall still holds the PC
         if (!bus.stall) pc_d = pc_plus4;
         id_valid_d    = 1'b0;
         id_pc_d       = 32'h0;
         id_pc_plus4_d = 32'h0;
         id_instru_d   = NOP_INSTR;
      end else if (!bus.stall) begin
         pc_d          = pc_plus4;
         id_valid_d    = 1'b1;
         id_pc_d       = pc_q;
         id_pc_plus4_d = pc_plus4;
         id_instru_d   = bus.imem_instru;
      end
   end

   // PC and IF/ID register
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         id_valid_q    <= 1'b0;
         id_pc_q       <= 32'h0;
         id_pc_plus4_q <= 32'h0;
         id_instru_q   <= NOP_INSTR;
      end else begin
         pc_q          <= pc_d;
         id_valid_q    <= id_valid_d;
         id_pc_q       <= id_pc_d;
         id_pc_plus4_q <= id_pc_plus4_d;
         id_instru_q   <= id_instru_d;
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.id_valid    = id_valid_q;
   assign bus.id_pc       = id_pc_q;
   assign bus.id_pc_plus4 = id_pc_plus4_q;
   assign bus.id_instru   = id_instru_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] cnt_fetched_q, cnt_fetched_d;
   logic [31:0] cnt_stall_q, cnt_stall_d;
   logic [31:0] cnt_flush_q, cnt_flush_d;
   logic        evt_fetch, evt_stall, evt_flush;

   assign evt_fetch = !bus.redirect && !bus.flush && !bus.stall;
   assign evt_stall = bus.stall && !bus.redirect;
   assign evt_flush = bus.flush || bus.redirect;

   // saturating event counters
   always_comb begin
      cnt_fetched_d = cnt_fetched_q;
      cnt_stall_d   = cnt_stall_q;
      cnt_flush_d   = cnt_flush_q;
      if (evt_fetch && (cnt_fetched_q != 32'hFFFF_FFFF)) cnt_fetched_d = cnt_fetched_q + 32'd1;
      if (evt_stall && (cnt_stall_q   != 32'hFFFF_FFFF)) cnt_stall_d   = cnt_stall_q + 32'd1;
      if (evt_flush && (cnt_flush_q   != 32'hFFFF_FFFF)) cnt_flush_d   = cnt_flush_q + 32'd1;
   end

   // counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_fetched_q <= 32'h0;
         cnt_stall_q   <= 32'h0;
         cnt_flush_q   <= 32'h0;
      end else begin
         cnt_fetched_q <= cnt_fetched_d;
         cnt_stall_q   <= cnt_stall_d;
         cnt_flush_q   <= cnt_flush_d;
      end
   end

   assign bus.cnt_fetched = cnt_fetched_q;
   assign bus.cnt_stall   = cnt_stall_q;
   assign bus.cnt_flush   = cnt_flush_q;
`else
   assign bus.cnt_fetched = 32'h0;
   assign bus.cnt_stall   = 32'h0;
   assign bus.cnt_flush   = 32'h0;
`endif

endmodule
